seq_magnitude_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands, signed or unsigned.
- Scans the operands MSB-first, DIGIT bits per cycle, and stops at the first digit where they differ.
- Reports one-hot gt/eq/lt flags through a start/busy/done handshake.
- Successor to the fixed 2-bit combinational comparator. Used wherever wide operands must be ordered without a full-width combinational compare.

---
 rtl/seq_magnitude_comparator_pkg.sv | 18 +
 rtl/digit_comparator.sv | 16 +
 rtl/seq_magnitude_comparator.sv | 112 +++++++++++
 tb/tb_seq_magnitude_comparator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// FSM state encoding and bit positions of the registered result vector.
package seq_magnitude_comparator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMP  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Result vector is {gt, eq, lt}
   localparam int R_GT = 2;
   localparam int R_EQ = 1;
   localparam int R_LT = 0;

   typedef logic [2:0] result_t;

endpackage

// File: rtl/digit_comparator.sv
// Combinational unsigned compare of one DIGIT-bit slice of each operand.
module digit_comparator #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   output logic             x_gt,
   output logic             x_eq,
   output logic             x_lt
);

   assign x_gt = (x > y);
   assign x_eq = (x == y);
   assign x_lt = (x < y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans operands MSB-first, DIGIT bits per
// cycle, and stops at the first differing digit.
module seq_magnitude_comparator
   import seq_magnitude_comparator_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int NDIG  = WIDTH / DIGIT;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NDIG - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state, state_next;
   result_t          res, res_next;
   logic [WIDTH-1:0] sa, sb;
   logic [WIDTH-1:0] sign_flip;
   logic [CNT_W-1:0] cnt;
   logic             load, shift;
   logic             d_gt, d_eq, d_lt;

   digit_comparator #(.DIGIT(DIGIT)) u_digit (
      .x    (sa[WIDTH-1 -: DIGIT]),
      .y    (sb[WIDTH-1 -: DIGIT]),
      .x_gt (d_gt),
      .x_eq (d_eq),
      .x_lt (d_lt)
   );

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   always_comb begin
      sign_flip            = '0;
      sign_flip[WIDTH-1]   = is_signed;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_next = state;
      res_next   = res;
      load       = 1'b0;
      shift      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_CMP;
               res_next   = '0;
               load       = 1'b1;
            end
         end
         ST_CMP: begin
            if (!d_eq) begin
               res_next       = '0;
               res_next[R_GT] = d_gt;
               res_next[R_LT] = d_lt;
               state_next     = ST_DONE;
            end else if (cnt == '0) begin
               res_next       = '0;
               res_next[R_EQ] = 1'b1;
               state_next     = ST_DONE;
            end else begin
               shift = 1'b1;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         res   <= '0;
      end else begin
         state <= state_next;
         res   <= res_next;
      end
   end

   // NOTE: operand shifters and counter carry no reset; they are always reloaded before use.
   always_ff @(posedge clk) begin
      if (load) begin
         sa  <= a ^ sign_flip;
         sb  <= b ^ sign_flip;
         cnt <= CNT_LOAD;
      end else if (shift) begin
         sa  <= sa << DIGIT;
         sb  <= sb << DIGIT;
         cnt <= cnt - CNT_ONE;
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);
   assign gt   = res[R_GT];
   assign eq   = res[R_EQ];
   assign lt   = res[R_LT];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench: three comparators (DIGIT = 1, 2, 4) share stimulus; a
// reference model pushes expected result and done cycle, a monitor pops on done.
module tb_seq_magnitude_comparator;

   localparam int W  = 8;
   localparam int NI = 3;

   typedef struct {
      logic [2:0]  res;
      int unsigned cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst, start, is_signed;
   logic [W-1:0] a, b;
   logic         busy [NI];
   logic         done [NI];
   logic         gt   [NI];
   logic         eq   [NI];
   logic         lt   [NI];

   int          digs [NI] = '{1, 2, 4};
   exp_t        exp_q [NI][$];
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_magnitude_comparator #(.WIDTH(W), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .a(a), .b(b),
      .busy(busy[0]), .done(done[0]), .gt(gt[0]), .eq(eq[0]), .lt(lt[0]));
   seq_magnitude_comparator #(.WIDTH(W), .DIGIT(2)) u_d2 (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .a(a), .b(b),
      .busy(busy[1]), .done(done[1]), .gt(gt[1]), .eq(eq[1]), .lt(lt[1]));
   seq_magnitude_comparator #(.WIDTH(W), .DIGIT(4)) u_d4 (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .a(a), .b(b),
      .busy(busy[2]), .done(done[2]), .gt(gt[2]), .eq(eq[2]), .lt(lt[2]));

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected {gt, eq, lt} from plain signed/unsigned arithmetic
   function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
      if (s) begin
         if ($signed(x) > $signed(y)) return 3'b100;
         if ($signed(x) < $signed(y)) return 3'b001;
      end else begin
         if (x > y) return 3'b100;
         if (x < y) return 3'b001;
      end
      return 3'b010;
   endfunction

   // Edges to decide: index (1 = MSB digit) of the first digit where x and y differ
   function automatic int unsigned k_of(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input int d);
      logic [W-1:0] diff;
      diff = x ^ y;
      for (int m = W - 1; m >= 0; m--)
         if (diff[m]) return (W - 1 - m) / d + 1;
      return W / d;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < NI; i++) begin
         if (done[i]) begin
            check($sformatf("done_expected_d%0d", digs[i]), exp_q[i].size() > 0, 1);
            if (exp_q[i].size() > 0) begin
               e = exp_q[i].pop_front();
               check($sformatf("result_d%0d", digs[i]), {gt[i], eq[i], lt[i]}, e.res);
               check($sformatf("done_cycle_d%0d", digs[i]), cyc, e.cyc);
               check($sformatf("busy_in_done_d%0d", digs[i]), busy[i], 1);
            end
         end else if (busy[i]) begin
            check($sformatf("flags_in_flight_d%0d", digs[i]), {gt[i], eq[i], lt[i]}, 0);
         end
      end
   end

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      @(negedge clk);
      a = x; b = y; is_signed = s; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < NI; i++)
         exp_q[i].push_back('{res: ref_res(x, y, s), cyc: cyc + k_of(x, y, digs[i])});
      a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
   endtask

   task automatic drain();
      int pending;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         pending = 0;
         for (int i = 0; i < NI; i++) pending += exp_q[i].size();
         if (pending == 0) return;
      end
      check("drain_timeout_pending", pending, 0);
      for (int i = 0; i < NI; i++) exp_q[i].delete();
   endtask

   task automatic check_idle_hold(input logic [2:0] r, input string tag);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("%s_busy_d%0d", tag, digs[i]), busy[i], 0);
         check($sformatf("%s_hold_d%0d", tag, digs[i]), {gt[i], eq[i], lt[i]}, r);
      end
   endtask

   task automatic run_job(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      issue(x, y, s);
      drain();
      @(negedge clk);
      check_idle_hold(ref_res(x, y, s), "after_done");
   endtask

   initial begin
      logic [W-1:0] rx, ry;
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("reset_busy_d%0d", digs[i]), busy[i], 0);
         check($sformatf("reset_done_d%0d", digs[i]), done[i], 0);
         check($sformatf("reset_flags_d%0d", digs[i]), {gt[i], eq[i], lt[i]}, 0);
      end
      rst = 1'b0;

      run_job(8'hC3, 8'h43, 1'b0);             // MSB digit decides
      run_job(8'h5A, 8'h5A, 1'b0);             // equal: full scan
      repeat (10) begin
         @(negedge clk);
         check_idle_hold(3'b010, "eq_hold");
      end
      run_job(8'h12, 8'h13, 1'b0);             // last digit decides
      run_job(8'h80, 8'h7F, 1'b1);             // signed: -128 < 127
      run_job(8'h80, 8'h7F, 1'b0);             // unsigned: 128 > 127

      // Second start while busy must be ignored
      issue(8'h01, 8'h02, 1'b0);
      @(negedge clk);
      a = 8'hFF; b = 8'h00; is_signed = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      drain();
      run_job(8'hFF, 8'h00, 1'b0);

      // Reset sampled at edge e0+2 aborts the job with no done pulse
      @(negedge clk);
      a = 8'hAA; b = 8'hAA; is_signed = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check_idle_hold(3'b000, "abort");
         for (int i = 0; i < NI; i++) check($sformatf("abort_done_d%0d", digs[i]), done[i], 0);
      end

      // rst and start together: reset wins
      @(negedge clk);
      a = 8'h01; b = 8'h00; rst = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 begin rst = 1'b0; start = 1'b0; end
      @(negedge clk);
      check_idle_hold(3'b000, "rst_start");

      for (int n = 0; n < 40; n++) begin
         rx = W'($urandom);
         ry = (n % 5 == 0) ? rx : W'($urandom);
         run_job(rx, ry, 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
